// File: rtl/ex_muldiv.sv
// ex_muldiv - iterative multiply/divide unit for the EX stage.
//
// Executes MULTU/MULT/DIVU/DIV on WIDTH-bit operands in one shared
// shift-based datapath (one step per cycle, WIDTH steps per op) and
// returns a 2*WIDTH-bit {HI,LO} result.
//
// Ports:
//   clk          clock, all state updates on the rising edge
//   rst          synchronous active-high reset
//   start_i      request an operation (sampled only in IDLE)
//   op_i         00 MULTU, 01 MULT, 10 DIVU, 11 DIV
//   opdata1_i    multiplicand / dividend
//   opdata2_i    multiplier / divisor
//   annul_i      flush: aborts any operation, blocks acceptance
//   stall_o      combinational pipeline stall request
//   ready_o      one-cycle result-valid pulse
//   divzero_o    the result came from a division by zero
//   result_o     {HI,LO}: mul = full product; div = {remainder, quotient}
//   dbg_state_o  FSM state (0 IDLE, 1 RUN, 2 DONE) for observation
//
// Handshake: an operation is accepted on the rising edge that ends a cycle
// in which the unit is IDLE, start_i=1 and annul_i=0. ready_o is a single
// cycle pulse; result_o/divzero_o are valid while ready_o=1 and then hold
// until the next accept. There is no back-pressure on the result.
module ex_muldiv #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start_i,
    input  logic [1:0]           op_i,
    input  logic [WIDTH-1:0]     opdata1_i,
    input  logic [WIDTH-1:0]     opdata2_i,
    input  logic                 annul_i,
    output logic                 stall_o,
    output logic                 ready_o,
    output logic                 divzero_o,
    output logic [2*WIDTH-1:0]   result_o,
    output logic [1:0]           dbg_state_o
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t               r_state;
    logic [CW-1:0]        r_cnt;
    logic [1:0]           r_op;
    logic                 r_neg_res;   // operand signs differ (product / quotient)
    logic                 r_neg_rem;   // dividend was negative (remainder sign)
    logic [WIDTH-1:0]     r_a;         // multiplicand or divisor magnitude
    logic [2*WIDTH-1:0]   r_acc;       // {acc_hi, multiplier} or {rem, quot}
    logic [2*WIDTH-1:0]   r_result;
    logic                 r_divzero;

    // ---------------- operand preparation ----------------
    logic                 w_is_div;
    logic                 w_is_signed;
    logic                 w_op1_neg;
    logic                 w_op2_neg;
    logic [WIDTH-1:0]     w_abs1;
    logic [WIDTH-1:0]     w_abs2;
    logic                 w_div_by_zero;
    logic                 w_accept;

    assign w_is_div      = op_i[1];
    assign w_is_signed   = op_i[0];
    assign w_op1_neg     = w_is_signed & opdata1_i[WIDTH-1];
    assign w_op2_neg     = w_is_signed & opdata2_i[WIDTH-1];
    // The most negative value negates to itself, which read as unsigned is
    // exactly its magnitude 2^(WIDTH-1).
    assign w_abs1        = w_op1_neg ? -opdata1_i : opdata1_i;
    assign w_abs2        = w_op2_neg ? -opdata2_i : opdata2_i;
    assign w_div_by_zero = w_is_div && (opdata2_i == '0);
    assign w_accept      = (r_state == S_IDLE) && start_i && !annul_i;

    // ---------------- multiply step ----------------
    // Low half of r_acc holds the unconsumed multiplier bits; its LSB decides
    // whether the multiplicand is added into the high half, then everything
    // shifts right by one (the carry lands in the top bit).
    logic [WIDTH:0]       w_mul_sum;
    logic [2*WIDTH-1:0]   w_mul_next;

    assign w_mul_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_a} : '0);
    assign w_mul_next = {w_mul_sum, r_acc[WIDTH-1:1]};

    // ---------------- restoring divide step ----------------
    // The shifted partial remainder can need WIDTH+1 bits, so the bit that
    // leaves the top of the upper half is kept for the trial subtraction.
    logic [WIDTH:0]       w_div_top;
    logic [WIDTH+1:0]     w_div_diff;
    logic                 w_div_ok;
    logic [2*WIDTH-1:0]   w_div_next;

    assign w_div_top  = r_acc[2*WIDTH-1:WIDTH-1];
    assign w_div_diff = {1'b0, w_div_top} - {2'b00, r_a};
    assign w_div_ok   = ~w_div_diff[WIDTH+1];
    assign w_div_next = {(w_div_ok ? w_div_diff[WIDTH-1:0] : w_div_top[WIDTH-1:0]),
                         r_acc[WIDTH-2:0], w_div_ok};

    logic [2*WIDTH-1:0]   w_step;
    assign w_step = r_op[1] ? w_div_next : w_mul_next;

    // ---------------- sign correction of the final step ----------------
    logic [WIDTH-1:0]     w_quot;
    logic [WIDTH-1:0]     w_rem;
    logic [WIDTH-1:0]     w_quot_fix;
    logic [WIDTH-1:0]     w_rem_fix;
    logic [2*WIDTH-1:0]   w_prod_fix;
    logic [2*WIDTH-1:0]   w_final;

    assign w_quot     = w_step[WIDTH-1:0];
    assign w_rem      = w_step[2*WIDTH-1:WIDTH];
    assign w_quot_fix = r_neg_res ? -w_quot : w_quot;
    assign w_rem_fix  = r_neg_rem ? -w_rem : w_rem;
    assign w_prod_fix = r_neg_res ? -w_step : w_step;
    assign w_final    = r_op[1] ? {w_rem_fix, w_quot_fix} : w_prod_fix;

    // ---------------- FSM ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_op      <= 2'b00;
            r_neg_res <= 1'b0;
            r_neg_rem <= 1'b0;
            r_a       <= '0;
            r_acc     <= '0;
            r_result  <= '0;
            r_divzero <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        if (w_div_by_zero) begin
                            r_result  <= '0;
                            r_divzero <= 1'b1;
                            r_state   <= S_DONE;
                        end else begin
                            r_divzero <= 1'b0;
                            r_op      <= op_i;
                            r_neg_res <= w_op1_neg ^ w_op2_neg;
                            r_neg_rem <= w_op1_neg;
                            r_a       <= w_is_div ? w_abs2 : w_abs1;
                            r_acc     <= {{WIDTH{1'b0}}, (w_is_div ? w_abs1 : w_abs2)};
                            r_cnt     <= '0;
                            r_state   <= S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    if (annul_i) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_acc <= w_step;
                        if (r_cnt == CW'(WIDTH - 1)) begin
                            r_result <= w_final;
                            r_state  <= S_DONE;
                        end else begin
                            r_cnt <= r_cnt + CW'(1);
                        end
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // ---------------- outputs ----------------
    assign ready_o     = (r_state == S_DONE) && !annul_i;
    assign stall_o     = ((r_state == S_IDLE) && start_i && !annul_i && !w_div_by_zero) ||
                         ((r_state == S_RUN) && !annul_i);
    assign divzero_o   = r_divzero;
    assign result_o    = r_result;
    assign dbg_state_o = r_state;

endmodule

// File: tb/tb_ex_muldiv.sv
// Testbench for ex_muldiv (WIDTH=32): directed cases, randomized operations
// checked against an arithmetic reference model, annul and reset scenarios.
module tb_ex_muldiv;

    localparam int W = 32;

    // ---------------- clock / reset ----------------
    logic           clk = 1'b0;
    logic           rst;
    logic           start_i;
    logic [1:0]     op_i;
    logic [W-1:0]   opdata1_i;
    logic [W-1:0]   opdata2_i;
    logic           annul_i;
    logic           stall_o;
    logic           ready_o;
    logic           divzero_o;
    logic [2*W-1:0] result_o;
    logic [1:0]     dbg_state_o;

    always #5 clk = ~clk;

    ex_muldiv #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .start_i     (start_i),
        .op_i        (op_i),
        .opdata1_i   (opdata1_i),
        .opdata2_i   (opdata2_i),
        .annul_i     (annul_i),
        .stall_o     (stall_o),
        .ready_o     (ready_o),
        .divzero_o   (divzero_o),
        .result_o    (result_o),
        .dbg_state_o (dbg_state_o)
    );

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_errors = 0;
    logic [2*W:0] exp_q[$];   // {divzero, result}

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference model: plain integer arithmetic on 64-bit values.
    function automatic logic [2*W:0] ref_model(input logic [1:0] op,
                                                input logic [W-1:0] a,
                                                input logic [W-1:0] b);
        longint     sa;
        longint     sb;
        longint     sq;
        longint     sr;
        logic [63:0] ua;
        logic [63:0] ub;
        logic [63:0] t;
        logic [63:0] q;
        logic [63:0] r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'b0, a};
        ub = {32'b0, b};
        case (op)
            2'b00: t = ua * ub;
            2'b01: t = sa * sb;
            default: t = '0;
        endcase
        if (op[1]) begin
            if (b == '0) return {1'b1, 64'b0};
            if (op[0]) begin
                sq = sa / sb;
                sr = sa % sb;
                q = sq;
                r = sr;
            end else begin
                q = ua / ub;
                r = ua % ub;
            end
            return {1'b0, r[31:0], q[31:0]};
        end
        return {1'b0, t};
    endfunction

    // ---------------- driver tasks ----------------
    // Called at posedge+1; returns at posedge+1 of the IDLE cycle after DONE.
    task automatic run_op(input string tag, input logic [1:0] op,
                          input logic [W-1:0] a, input logic [W-1:0] b);
        logic [2*W:0] exp_v;
        logic [2*W:0] got_v;
        int lat;
        int stalls;
        int exp_lat;
        exp_v = ref_model(op, a, b);
        exp_q.push_back(exp_v);
        exp_lat = exp_v[2*W] ? 1 : W + 1;
        start_i   = 1'b1;
        op_i      = op;
        opdata1_i = a;
        opdata2_i = b;
        lat    = -1;
        stalls = 0;
        for (int k = 0; k < 3 * W && lat < 0; k++) begin
            @(negedge clk);
            if (stall_o) stalls++;
            if (ready_o) begin
                lat   = k;
                got_v = {divzero_o, result_o};
                check({tag, " result"}, got_v[63:0], exp_q[0][63:0]);
                check({tag, " divzero"}, 64'(got_v[2*W]), 64'(exp_q[0][2*W]));
                void'(exp_q.pop_front());
            end
            @(posedge clk);
            #1;
            start_i = 1'b0;
        end
        check({tag, " latency"}, 64'(lat), 64'(exp_lat));
        check({tag, " stall cycles"}, 64'(stalls), exp_v[2*W] ? 64'd0 : 64'(W + 1));
        if (lat < 0) exp_q.delete();
    endtask

    task automatic count_ready(input int n, output int seen);
        seen = 0;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            if (ready_o) seen++;
            @(posedge clk);
            #1;
        end
    endtask

    function automatic logic [W-1:0] pick_operand();
        case ($urandom_range(0, 5))
            0: return 32'h0000_0000;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return W'($urandom_range(0, 20));
            4: return -W'($urandom_range(1, 20));
            default: return $urandom;
        endcase
    endfunction

    // ---------------- main sequence ----------------
    initial begin
        int seen;
        rst       = 1'b1;
        start_i   = 1'b0;
        op_i      = 2'b00;
        opdata1_i = '0;
        opdata2_i = '0;
        annul_i   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        @(negedge clk);
        check("reset result", result_o, 64'd0);
        check("reset divzero", 64'(divzero_o), 64'd0);
        check("reset ready", 64'(ready_o), 64'd0);
        check("reset stall", 64'(stall_o), 64'd0);
        check("reset state", 64'(dbg_state_o), 64'd0);
        @(posedge clk);
        #1;

        // Directed cases
        run_op("multu max", 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        check("multu max const", result_o, 64'hFFFF_FFFE_0000_0001);
        run_op("mult -3x7", 2'b01, -32'd3, 32'd7);
        check("mult -3x7 const", result_o, 64'hFFFF_FFFF_FFFF_FFEB);
        run_op("mult min*min", 2'b01, 32'h8000_0000, 32'h8000_0000);
        check("mult min*min const", result_o, 64'h4000_0000_0000_0000);
        run_op("div -7/2", 2'b11, -32'd7, 32'd2);
        check("div -7/2 const", result_o, 64'hFFFF_FFFF_FFFF_FFFD);
        run_op("divu 100/7", 2'b10, 32'd100, 32'd7);
        check("divu 100/7 const", result_o, {32'd2, 32'd14});
        run_op("div min/-1", 2'b11, 32'h8000_0000, 32'hFFFF_FFFF);
        check("div min/-1 const", result_o, 64'h0000_0000_8000_0000);
        run_op("divu by 0", 2'b10, 32'd100, 32'd0);
        check("divu by 0 const", result_o, 64'd0);
        run_op("divu after dz", 2'b10, 32'd9, 32'd4);
        check("divzero cleared", 64'(divzero_o), 64'd0);

        // Annul in RUN cycle 10
        start_i   = 1'b1;
        op_i      = 2'b10;
        opdata1_i = 32'd1000;
        opdata2_i = 32'd3;
        @(posedge clk);
        #1;
        start_i = 1'b0;
        count_ready(9, seen);
        annul_i = 1'b1;
        @(negedge clk);
        check("annul ready", 64'(ready_o), 64'd0);
        check("annul stall", 64'(stall_o), 64'd0);
        @(posedge clk);
        #1;
        annul_i = 1'b0;
        check("annul state idle", 64'(dbg_state_o), 64'd0);
        check("annul no ready seen", 64'(seen), 64'd0);
        check("annul result kept", result_o, {32'd1, 32'd2});
        run_op("multu 3x5", 2'b00, 32'd3, 32'd5);

        // Reset in RUN cycle 5
        start_i   = 1'b1;
        op_i      = 2'b00;
        opdata1_i = 32'd7;
        opdata2_i = 32'd9;
        @(posedge clk);
        #1;
        start_i = 1'b0;
        count_ready(4, seen);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst mid-run result", result_o, 64'd0);
        check("rst mid-run state", 64'(dbg_state_o), 64'd0);
        count_ready(W + 4, seen);
        check("rst mid-run no ready", 64'(seen), 64'd0);

        // Start together with annul in IDLE
        start_i   = 1'b1;
        annul_i   = 1'b1;
        op_i      = 2'b00;
        opdata1_i = 32'd2;
        opdata2_i = 32'd2;
        @(negedge clk);
        check("start+annul stall", 64'(stall_o), 64'd0);
        @(posedge clk);
        #1;
        start_i = 1'b0;
        annul_i = 1'b0;
        check("start+annul state", 64'(dbg_state_o), 64'd0);
        count_ready(3, seen);
        check("start+annul no ready", 64'(seen), 64'd0);

        // Randomized operations
        for (int i = 0; i < 30; i++) begin
            run_op($sformatf("rand%0d", i), 2'($urandom_range(0, 3)), pick_operand(), pick_operand());
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/ex_muldiv.md
# ex_muldiv

Iterative multiply/divide unit for the EX stage of the flowCPU MIPS32 pipeline. It executes MULT, MULTU, DIV and DIVU on WIDTH-bit operands in one shared shift-based datapath and returns a 2*WIDTH-bit {HI,LO} result. While an operation is in flight it raises a stall to the pipeline, and it can be annulled by an exception flush. The ALU's one-cycle logic path is unchanged; EX selects this block's result for mul/div instructions.

## Interface
Parameters:
- WIDTH, 32: operand width. Must be at least 2.

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  reset: one clock; reset is synchronous and active-high
- start_i  in  1  request an operation; sampled only in IDLE
- op_i  in  2  operation: 00 MULTU, 01 MULT, 10 DIVU, 11 DIV
- opdata1_i  in  WIDTH  multiplicand / dividend
- opdata2_i  in  WIDTH  multiplier / divisor
- annul_i  in  1  flush; aborts any operation, blocks acceptance
- stall_o  out  1  combinational pipeline stall request
- ready_o  out  1  one-cycle result-valid pulse
- divzero_o  out  1  qualifies ready_o: the result came from a division by zero
- result_o  out  2*WIDTH  {HI,LO}; mul: full product; div: HI=remainder, LO=quotient

## Operation
- States: IDLE, RUN, DONE. The counter cnt counts 0..WIDTH-1.
- Accept: in IDLE, when start_i=1 and annul_i=0.
  - Divide with opdata2_i==0: go straight to DONE. The result register is set to 0 and divzero_o is set to 1.
  - Otherwise: latch the operand magnitudes, the result signs and op; clear cnt; go to RUN.
- Signed ops (MULT, DIV): operands are converted to absolute value in WIDTH-bit unsigned form. The most negative value maps to 2^(WIDTH-1).
- Unsigned ops use the operands as-is.
- RUN, multiply: one shift-add step per cycle, LSB of the multiplier first, into a 2*WIDTH accumulator.
- RUN, divide: one restoring step per cycle. Shift the {rem,quot} pair left, then trial-subtract the divisor from the upper half.
- RUN ends when cnt==WIDTH-1; that edge moves the state to DONE.
- On entry to DONE, sign correction is applied:
  - product: negated (two's complement, 2*WIDTH bits) when the operand signs differ;
  - quotient: negated when the signs differ;
  - remainder: takes the sign of the dividend.
- Width rules:
  - MULT of the most negative value by itself gives 2^(2*WIDTH-2) positive.
  - DIV of the most negative value by -1 wraps: LO = most negative value, HI = 0.
- DONE lasts one cycle, then the state returns to IDLE unconditionally. Requests are never accepted in DONE.
- ready_o = (state==DONE) && !annul_i.
- result_o and divzero_o hold until the next accept. An accept clears divzero_o unless the new op is also a divide by zero.
- stall_o = (state==IDLE && start_i && !annul_i && !(div && opdata2_i==0)) || (state==RUN && !annul_i).
- annul_i in RUN: next state is IDLE, no ready_o pulse, result_o keeps its previous value.
- annul_i in DONE: ready_o is suppressed; the state still goes to IDLE.
- annul_i and start_i both high in IDLE: nothing is accepted.
- rst (synchronous, has priority over everything): state=IDLE, cnt=0, result_o=0, divzero_o=0. Hence ready_o=0 and stall_o follows start_i/annul_i combinationally.
- Reset mid-RUN discards the operation; no ready_o follows.

## Timing
- Accept edge E0 for a normal op: RUN covers the cycles after E0 through edge E_WIDTH; DONE occupies the cycle after E_WIDTH.
- ready_o is high exactly WIDTH+1 cycles after the accept cycle (33 cycles for WIDTH=32).
- stall_o is high from the accept cycle through the last RUN cycle. It is low in DONE, so the pipeline advances with result_o valid in that cycle.
- Divide by zero: ready_o and divzero_o are high in the cycle right after the accept cycle. stall_o is never asserted.
- Back-to-back ops: the earliest next accept is the cycle after DONE. Throughput is one op per WIDTH+2 cycles.

## Test plan
- MULTU 0xFFFFFFFF x 0xFFFFFFFF (WIDTH=32) -> ready_o in cycle 33 after accept; result_o=0xFFFFFFFE_00000001; stall_o high for exactly 33 cycles.
- MULT -3 x 7 -> result_o=0xFFFFFFFF_FFFFFFEB. MULT 0x80000000 x 0x80000000 -> 0x40000000_00000000.
- DIV -7 / 2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU 100 / 7 -> LO=14, HI=2.
- DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0. DIVU 100 / 0 -> next cycle ready_o=1, divzero_o=1, result_o=0, stall_o never high.
- Start DIVU, assert annul_i in RUN cycle 10 -> no ready_o, IDLE next cycle, stall_o low. A MULTU 3x5 accepted immediately after -> 15.
- Assert rst in RUN cycle 5 -> result_o=0 and IDLE after the edge, no ready_o. Start with annul_i=1 in IDLE -> no accept.
